reaction_timer: RTL



---
 rtl/reaction_timer_if.sv | 49 ++++
 rtl/reaction_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_if.sv
// rtl/reaction_timer_if.sv - bus bundle between start-light sequencer and reaction timer
//
// Purpose: groups the reaction timer's event inputs and result outputs.
// Optional feature macro: REACTION_BEST_EN (adds best_ms).
// Signals:
//   tick        1  1 ms enable, one clk cycle wide
//   arm         1  light sequence started (pulse)
//   lights_out  1  all lights extinguished (pulse)
//   trigger     1  driver button level, asynchronous to clk
//   reaction_ms W  latched result
//   valid       1  reaction_ms holds a genuine reaction time
//   jump_start  1  button pressed before lights-out
//   timeout     1  no press within MAX_MS
//   busy        1  waiting for lights-out or counting
//   best_ms     W  best valid time since reset (REACTION_BEST_EN only)
// Modports: master drives events and reads results, slave is the timer.

interface reaction_timer_if #(
   parameter int W = 14
);
   logic         tick;
   logic         arm;
   logic         lights_out;
   logic         trigger;
   logic [W-1:0] reaction_ms;
   logic         valid;
   logic         jump_start;
   logic         timeout;
   logic         busy;
`ifdef REACTION_BEST_EN
   logic [W-1:0] best_ms;
`endif

   modport master (
      output tick, arm, lights_out, trigger,
`ifdef REACTION_BEST_EN
      input  best_ms,
`endif
      input  reaction_ms, valid, jump_start, timeout, busy
   );

   modport slave (
      input  tick, arm, lights_out, trigger,
`ifdef REACTION_BEST_EN
      output best_ms,
`endif
      output reaction_ms, valid, jump_start, timeout, busy
   );
endinterface

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - driver reaction time measurement in 1 ms ticks
//
// Purpose: counts ticks from lights-out to the first rising edge of the
// driver button and reports a valid time, a jump start or a timeout.
// Optional feature macro: REACTION_BEST_EN (tracks best valid time in best_ms).
// Parameters:
//   W       counter / result width
//   MAX_MS  saturation value, must be < 2^W
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of reaction_timer_if (events in, results out)

module reaction_timer #(
   parameter int W      = 14,
   parameter int MAX_MS = 9999
) (
   input  logic              clk,
   input  logic              rst,
   reaction_timer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_TIMING,
      S_DONE,
      S_JUMP,
      S_TOUT
   } state_t;

   localparam logic [W-1:0] MAX_VAL = W'(MAX_MS);

   state_t       r_state;
   state_t       w_nxt_state;
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_nxt_cnt;
   logic [W-1:0] r_reaction_ms;
   logic [W-1:0] w_nxt_ms;
   logic         r_valid;
   logic         w_nxt_valid;
   logic         r_jump;
   logic         w_nxt_jump;
   logic         r_tout;
   logic         w_nxt_tout;
   logic         r_busy;

   logic         r_sync1;
   logic         r_sync2;
   logic         r_sync3;
   logic         w_trig_edge;

   // Two-flop synchronizer for the asynchronous button plus one history
   // flop so only a rising edge is seen; a held button never re-fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= bus.trigger;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_trig_edge = r_sync2 & ~r_sync3;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_ms    = r_reaction_ms;
      w_nxt_valid = r_valid;
      w_nxt_jump  = r_jump;
      w_nxt_tout  = r_tout;

      if (bus.arm) begin
         // arm overrides every other event in the same cycle
         w_nxt_state = S_ARMED;
         w_nxt_cnt   = '0;
         w_nxt_ms    = '0;
         w_nxt_valid = 1'b0;
         w_nxt_jump  = 1'b0;
         w_nxt_tout  = 1'b0;
      end else begin
         case (r_state)
            S_ARMED: begin
               if (w_trig_edge && bus.lights_out) begin
                  // press coincides with lights-out: zero reaction, not a jump
                  w_nxt_state = S_DONE;
                  w_nxt_ms    = '0;
                  w_nxt_valid = 1'b1;
               end else if (w_trig_edge) begin
                  w_nxt_state = S_JUMP;
                  w_nxt_jump  = 1'b1;
               end else if (bus.lights_out) begin
                  w_nxt_state = S_TIMING;
                  w_nxt_cnt   = '0;
               end
            end
            S_TIMING: begin
               // the press wins over a coincident tick, so its increment is dropped
               if (w_trig_edge) begin
                  w_nxt_state = S_DONE;
                  w_nxt_ms    = r_cnt;
                  w_nxt_valid = 1'b1;
               end else if (bus.tick) begin
                  if (r_cnt == MAX_VAL) begin
                     w_nxt_state = S_TOUT;
                     w_nxt_ms    = MAX_VAL;
                     w_nxt_tout  = 1'b1;
                  end else begin
                     w_nxt_cnt = r_cnt + 1'b1;
                  end
               end
            end
            default: begin
               // IDLE, DONE, JUMP, TOUT hold everything until the next arm
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_reaction_ms <= '0;
         r_valid       <= 1'b0;
         r_jump        <= 1'b0;
         r_tout        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_cnt         <= w_nxt_cnt;
         r_reaction_ms <= w_nxt_ms;
         r_valid       <= w_nxt_valid;
         r_jump        <= w_nxt_jump;
         r_tout        <= w_nxt_tout;
         // registered from the next state so busy changes on the transition edge
         r_busy        <= (w_nxt_state == S_ARMED) || (w_nxt_state == S_TIMING);
      end
   end

   assign bus.reaction_ms = r_reaction_ms;
   assign bus.valid       = r_valid;
   assign bus.jump_start  = r_jump;
   assign bus.timeout     = r_tout;
   assign bus.busy        = r_busy;

`ifdef REACTION_BEST_EN
   logic [W-1:0] r_best;
   logic [W-1:0] w_nxt_best;

   // DONE is only entered from ARMED/TIMING, so entering it marks a fresh result
   always_comb begin
      w_nxt_best = r_best;
      if ((w_nxt_state == S_DONE) && (r_state != S_DONE) && (w_nxt_ms < r_best))
         w_nxt_best = w_nxt_ms;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_best <= MAX_VAL;
      else
         r_best <= w_nxt_best;
   end

   assign bus.best_ms = r_best;
`endif

endmodule
